// File: rtl/bcd_pkg.sv
// Shared BCD converter definitions: state encoding and digit width.
// Used by both the BCD-to-binary and binary-to-BCD blocks.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] INICIALIZA = 3'd1;
  localparam logic [2:0] SHIFTA     = 3'd2;
  localparam logic [2:0] CORRIGE    = 3'd3;
  localparam logic [2:0] FIM        = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = IDLE,
    S_INIT = INICIALIZA,
    S_SHFT = SHIFTA,
    S_CORR = CORRIGE,
    S_FIM  = FIM
  } state_t;

endpackage

// File: rtl/bcd_digit_sub3.sv
// One BCD digit correction step of reverse double-dabble:
// subtract 3 when the digit is 8 or more.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] q_o
);

  assign q_o = d_i[DIGIT_W-1] ? d_i - DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Optional invalid-digit flag output erro under BCD2BIN_CHECK_EN.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int N = 24,
  parameter int W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] bcd,
  output logic         pronto,
`ifdef BCD2BIN_CHECK_EN
  output logic         erro,
`endif
  output logic [W-1:0] binary
);

  localparam int NDIG = N / DIGIT_W;
  localparam int CW   = $clog2(W + 1);

  state_t        state_q, state_d;
  logic [N-1:0]  bcd_q, bcd_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  corr;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_sub3 u_sub3 (
      .d_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .q_o (corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        bcd_d   = bcd;
        bin_d   = '0;
        cnt_d   = '0;
        state_d = S_SHFT;
      end
      S_SHFT: begin
        {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
        state_d = (cnt_q == CW'(W - 1)) ? S_FIM : S_CORR;
      end
      S_CORR: begin
        bcd_d   = corr;
        cnt_d   = cnt_q + CW'(1);
        state_d = S_SHFT;
      end
      S_FIM: if (start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pronto = (state_q == S_FIM);
  assign binary = bin_q;

`ifdef BCD2BIN_CHECK_EN
  logic bad;
  logic flag_q;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) bad = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)                 flag_q <= 1'b0;
    else if (state_q == S_INIT) flag_q <= bad;
  end

  assign erro = flag_q & pronto;
`endif

endmodule
